// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
// Contents:
//   size_e         access size encoding (byte, half, word, reserved)
//   state_e        load/store FSM states
//   access_bytes() number of bytes touched by an access of a given size
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // The reserved size reports 4 bytes.  It is rejected on its own, so this
  // value only feeds the range check.
  function automatic logic [2:0] access_bytes(input size_e size);
    case (size)
      SZ_BYTE: access_bytes = 3'd1;
      SZ_HALF: access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data-memory bundle of the load/store unit
// Ports (seen from the unit, modport slave):
//   request  : req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i in; req_ready_o out
//   response : resp_ready_i in; resp_valid_o, resp_rdata_o, resp_err_o out
//   memory   : mem_rdata_i in; mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o out
// The modport master is the mirror image, used by the environment.
interface load_store_unit_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;

  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  logic [31:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o,
    output resp_valid_o, resp_rdata_o, resp_err_o,
    input  resp_ready_i,
    output mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o,
    input  resp_valid_o, resp_rdata_o, resp_err_o,
    output resp_ready_i,
    input  mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - lane extraction/extension for loads and lane merge for sub-word stores
// Ports:
//   word_i     in  32  word read from memory
//   offset_i   in  2   byte offset of the access inside the word
//   size_i     in  2   access size
//   unsigned_i in  1   1 = zero-extend loads, 0 = sign-extend
//   wdata_i    in  32  right-aligned store data
//   load_o     out 32  extended load value
//   merged_o   out 32  word_i with the target lane replaced by store data
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] ins;

  assign shamt   = {offset_i, 3'b000};
  assign shifted = word_i >> shamt;

  always_comb begin
    load_o = word_i;
    mask   = 32'hFFFF_FFFF;
    ins    = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = unsigned_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        mask   = 32'h0000_00FF << shamt;
        ins    = {24'h0, wdata_i[7:0]} << shamt;
      end
      SZ_HALF: begin
        load_o = unsigned_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        mask   = 32'h0000_FFFF << shamt;
        ins    = {16'h0, wdata_i[15:0]} << shamt;
      end
      default: ;
    endcase
  end

  assign merged_o = (word_i & ~mask) | (ins & mask);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load/store unit in front of a word-wide data memory
// Ports:
//   clk_i    in  1  clock
//   reset_n  in  1  asynchronous active-low reset
//   bus      load_store_unit_if.slave  request/response handshake and memory port
// Parameters:
//   MEM_BYTES  memory size in bytes; accesses reaching past it are errors
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32
) (
  input logic              clk_i,
  input logic              reset_n,
  load_store_unit_if.slave bus
);

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  size_e       req_size;
  logic        accept;
  logic        req_err;
  logic [32:0] req_end;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign req_size = size_e'(bus.req_size_i);
  assign accept   = bus.req_valid_i && bus.req_ready_o;

  // End address computed one bit wider so accesses near 2^32 cannot wrap
  // back into range.
  assign req_end = {1'b0, bus.req_addr_i} + {30'h0, access_bytes(req_size)};
  assign req_err = (req_size == SZ_RSVD)
                || ((req_size == SZ_HALF) && bus.req_addr_i[0])
                || ((req_size == SZ_WORD) && (bus.req_addr_i[1:0] != 2'b00))
                || (req_end > 33'(MEM_BYTES));

  lsu_byte_lane u_lane (
    .word_i     (bus.mem_rdata_i),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merged_o   (lane_merged)
  );

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          size_d  = req_size;
          uns_d   = bus.req_unsigned_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          rdata_d = 32'h0;
          err_d   = req_err;
          if (req_err)                 state_d = ST_RESP;
          else if (!bus.req_we_i)      state_d = ST_RD;
          else if (req_size == SZ_WORD) state_d = ST_WR;
          else                         state_d = ST_RMW_RD;
        end
      end
      ST_RD: begin
        rdata_d = lane_load;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        // The merged word reuses the store-data register; WR then writes
        // wdata_q for both word and sub-word stores.
        wdata_d = lane_merged;
        state_d = ST_WR;
      end
      ST_WR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset drops mem_we_o without waiting for a clock edge.
  assign bus.req_ready_o  = (state_q == ST_IDLE) && reset_n;
  assign bus.mem_re_o     = (state_q == ST_RD) || (state_q == ST_RMW_RD);
  assign bus.mem_we_o     = (state_q == ST_WR);
  assign bus.mem_addr_o   = (bus.mem_re_o || bus.mem_we_o) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata_o  = bus.mem_we_o ? wdata_q : 32'h0;
  assign bus.resp_valid_o = (state_q == ST_RESP);
  assign bus.resp_rdata_o = bus.resp_valid_o ? rdata_q : 32'h0;
  assign bus.resp_err_o   = bus.resp_valid_o && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-array reference model
module tb_load_store_unit;

  logic clk_i = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_i = ~clk_i;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(32)) dut (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Data memory: 8 words, combinational read, written on the clock edge.
  logic [31:0] mem [8];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = 3'd0;
  logic [31:0] pl_data = 32'h0;
  int          re_cnt = 0;
  int          we_cnt = 0;
  int          excl_bad = 0;

  assign bus.mem_rdata_i = mem[bus.mem_addr_o[4:2]];

  always @(posedge clk_i) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.mem_we_o) mem[bus.mem_addr_o[4:2]] <= bus.mem_wdata_o;
    if (bus.mem_re_o) re_cnt <= re_cnt + 1;
    if (bus.mem_we_o) we_cnt <= we_cnt + 1;
    if ((bus.mem_re_o && bus.mem_we_o) || (bus.resp_valid_o && (bus.mem_re_o || bus.mem_we_o)))
      excl_bad <= excl_bad + 1;
  end

  // Reference model: memory as a flat byte array, little-endian.
  logic [7:0] ref_bytes [32];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = 3'(idx);
    pl_data = data;
    @(posedge clk_i); #1;
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = data[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
  endfunction

  // Expected outcome of one access from the access rules; stores update the model.
  task automatic ref_eval(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int n_re, output int n_we);
    int nb;
    longint v;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    er = (size == 2'd3) || ((addr % nb) != 0) || (longint'(addr) + nb > 32);
    rd = 32'h0; lat = 1; n_re = 0; n_we = 0;
    if (!er) begin
      if (!we) begin
        v = 0;
        for (int i = 0; i < nb; i++) v += longint'(ref_bytes[int'(addr)+i]) << (8*i);
        if (!uns && v[8*nb-1]) v -= (64'sd1 << (8*nb));
        rd = v[31:0]; lat = 2; n_re = 1;
      end else begin
        for (int i = 0; i < nb; i++) ref_bytes[int'(addr)+i] = wdata[8*i +: 8];
        lat  = (nb == 4) ? 2 : 3;
        n_re = (nb == 4) ? 0 : 1;
        n_we = 1;
      end
    end
  endtask

  // One access; called and returns at #1 after a rising edge with the unit idle.
  task automatic run_access(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wdata, input int hold,
                            output logic [31:0] got_rd);
    logic [31:0] exp_rd, rd0;
    logic        exp_er, er0;
    int          exp_lat, exp_re, exp_we, lat, re0, we0;
    ref_eval(we, size, uns, addr, wdata, exp_rd, exp_er, exp_lat, exp_re, exp_we);
    check({tag, " ready"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    bus.resp_ready_i   = (hold == 0);
    re0 = re_cnt; we0 = we_cnt;
    @(posedge clk_i); #1;
    // Scramble request fields to prove the unit latched them.
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    bus.req_size_i  = 2'($urandom);
    bus.req_unsigned_i = 1'($urandom);
    lat = 1;
    while (!bus.resp_valid_o && lat < 10) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, bus.resp_rdata_o, exp_rd);
    check({tag, " err"}, 32'(bus.resp_err_o), 32'(exp_er));
    got_rd = bus.resp_rdata_o;
    rd0 = bus.resp_rdata_o; er0 = bus.resp_err_o;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid_i = 1'b1;  // must be ignored outside IDLE
      bus.req_we_i    = 1'($urandom);
      @(posedge clk_i); #1;
      check({tag, " hold valid"}, 32'(bus.resp_valid_o), 32'd1);
      check({tag, " hold rdata"}, bus.resp_rdata_o, rd0);
      check({tag, " hold err"}, 32'(bus.resp_err_o), 32'(er0));
      check({tag, " hold ready"}, 32'(bus.req_ready_o), 32'd0);
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    check({tag, " idle ready"}, 32'(bus.req_ready_o), 32'd1);
    check({tag, " idle valid"}, 32'(bus.resp_valid_o), 32'd0);
    check({tag, " re pulses"}, 32'(re_cnt - re0), 32'(exp_re));
    check({tag, " we pulses"}, 32'(we_cnt - we0), 32'(exp_we));
    if (we && !exp_er) check({tag, " mem word"}, mem[addr[4:2]], ref_word(int'(addr[4:2])));
  endtask

  logic [31:0] rd;
  logic [31:0] a;
  logic [1:0]  sz;

  initial begin
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h0; bus.req_wdata_i = 32'h0;
    bus.resp_ready_i = 1'b1;

    for (int i = 0; i < 8; i++) preload(i, $urandom);
    preload(1, 32'h8899AABB);
    preload(2, 32'h11223344);

    check("rst ready", 32'(bus.req_ready_o), 32'd0);
    check("rst valid", 32'(bus.resp_valid_o), 32'd0);
    check("rst rdata", bus.resp_rdata_o, 32'h0);
    check("rst err", 32'(bus.resp_err_o), 32'd0);
    check("rst mem", {bus.mem_addr_o[29:0], bus.mem_re_o, bus.mem_we_o}, 32'h0);
    check("rst wdata", bus.mem_wdata_o, 32'h0);
    reset_n = 1'b1;
    @(posedge clk_i); #1;

    run_access("lb", 1'b0, 2'd0, 1'b0, 32'h05, 32'h0, 0, rd);
    check("lb value", rd, 32'hFFFFFFAA);
    run_access("lbu", 1'b0, 2'd0, 1'b1, 32'h05, 32'h0, 0, rd);
    check("lbu value", rd, 32'h000000AA);
    run_access("sb", 1'b1, 2'd0, 1'b0, 32'h0A, 32'h000000EE, 0, rd);
    check("sb word", mem[2], 32'h11EE3344);
    run_access("sw", 1'b1, 2'd2, 1'b0, 32'h1C, 32'hDEADBEEF, 0, rd);
    check("sw word", mem[7], 32'hDEADBEEF);
    run_access("lh", 1'b0, 2'd1, 1'b0, 32'h1E, 32'h0, 0, rd);
    check("lh value", rd, 32'hFFFFDEAD);
    run_access("lhu", 1'b0, 2'd1, 1'b1, 32'h1E, 32'h0, 0, rd);
    check("lhu value", rd, 32'h0000DEAD);

    run_access("err lh03", 1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 0, rd);
    run_access("err lw06", 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 0, rd);
    run_access("err lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, rd);
    run_access("err rsvd", 1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 0, rd);
    run_access("err swwrap", 1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h1, 0, rd);
    run_access("hold lw", 1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, 5, rd);

    // Reset while a sub-word store sits in WR.
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd0;
    bus.req_addr_i = 32'h0D; bus.req_wdata_i = 32'h55; bus.resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("mid we high", 32'(bus.mem_we_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid we drop", 32'(bus.mem_we_o), 32'd0);
    check("mid re", 32'(bus.mem_re_o), 32'd0);
    check("mid addr", bus.mem_addr_o, 32'h0);
    check("mid wdata", bus.mem_wdata_o, 32'h0);
    check("mid ready", 32'(bus.req_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("mid no resp", {bus.resp_rdata_o[30:0], bus.resp_valid_o}, 32'h0);
    end
    for (int i = 0; i < 4; i++) ref_bytes[12+i] = mem[3][8*i +: 8];
    reset_n = 1'b1;
    @(posedge clk_i); #1;
    run_access("post rst sh", 1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000CAFE, 0, rd);
    run_access("post rst lw", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 0, rd);

    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 39));
      if ($urandom_range(0, 3) != 0) a = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & ~32'h1) : (a & ~32'h3);
      run_access("rand", 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2), rd);
    end

    check("re/we exclusive", 32'(excl_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
